// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the data memory (slave).
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: holds one instruction, issues its load/store, stalls until ack
// and traps into a sticky error state when the memory never answers.
//
// state  | meaning
// S_RUN  | idle or single-cycle access; instructions flow through
// S_WAIT | access outstanding; wait_cnt counts cycles spent here
// S_ERR  | ack timed out; pipeline frozen until reset
module memory_stage #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_mem_write_i,
    input  logic [15:0]          ex_alu_result_i,
    input  logic [15:0]          ex_store_data_i,
    input  logic [15:0]          ex_pc_plus2_i,
    input  logic                 ex_branch_i,
    input  logic [2:0]           ex_branch_cond_i,
    input  logic [2:0]           ex_flags_i,
    input  logic                 ex_reg_write_i,
    input  logic                 ex_reg_write_src_i,
    input  logic [3:0]           ex_dst_reg_i,
    input  logic                 flush_i,
    memory_stage_if.master       dmem,
    output logic                 wb_valid_o,
    output logic                 wb_branch_o,
    output logic                 wb_reg_write_o,
    output logic                 wb_reg_write_src_o,
    output logic [2:0]           wb_branch_cond_o,
    output logic [2:0]           wb_flags_o,
    output logic [3:0]           wb_dst_reg_o,
    output logic [15:0]          wb_pc_plus2_o,
    output logic [15:0]          wb_alu_result_o,
    output logic [15:0]          wb_mem_read_o,
    output logic                 stall_o,
    output logic                 mem_error_o
);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] alu_result;
        logic [15:0] store_data;
        logic [15:0] pc_plus2;
        logic        branch;
        logic [2:0]  branch_cond;
        logic [2:0]  flags;
        logic        reg_write;
        logic        reg_write_src;
        logic [3:0]  dst_reg;
    } stage_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    stage_t     m_q, m_d;
    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_error_q, mem_error_d;
    logic       mem_op;
    logic       stall;

    always_comb begin
        mem_op = m_q.valid & (m_q.mem_read | m_q.mem_write) & ~flush_i & (state_q != S_ERR);
        stall  = (mem_op & ~dmem.ack) | (state_q == S_ERR);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        case (state_q)
            S_RUN: begin
                if (mem_op && !dmem.ack) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (dmem.ack || flush_i) begin
                    state_d = S_RUN;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d     = S_ERR;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RUN;
        endcase
    end

    // A flush kills the held instruction even while the stage is frozen.
    always_comb begin
        m_d = m_q;
        if (!stall) begin
            m_d.valid         = ex_valid_i & ~flush_i;
            m_d.mem_read      = ex_mem_read_i;
            m_d.mem_write     = ex_mem_write_i;
            m_d.alu_result    = ex_alu_result_i;
            m_d.store_data    = ex_store_data_i;
            m_d.pc_plus2      = ex_pc_plus2_i;
            m_d.branch        = ex_branch_i;
            m_d.branch_cond   = ex_branch_cond_i;
            m_d.flags         = ex_flags_i;
            m_d.reg_write     = ex_reg_write_i;
            m_d.reg_write_src = ex_reg_write_src_i;
            m_d.dst_reg       = ex_dst_reg_i;
        end else if (flush_i) begin
            m_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q         <= '0;
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            m_q         <= m_d;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign dmem.req   = mem_op;
    assign dmem.we    = mem_op & m_q.mem_write;
    assign dmem.addr  = m_q.alu_result;
    assign dmem.wdata = m_q.store_data;

    assign stall_o            = stall;
    assign mem_error_o        = mem_error_q;
    assign wb_valid_o         = m_q.valid & ~stall & ~flush_i;
    assign wb_branch_o        = m_q.branch & wb_valid_o;
    assign wb_reg_write_o     = m_q.reg_write & wb_valid_o;
    assign wb_reg_write_src_o = m_q.reg_write_src;
    assign wb_branch_cond_o   = m_q.branch_cond;
    assign wb_flags_o         = m_q.flags;
    assign wb_dst_reg_o       = m_q.dst_reg;
    assign wb_pc_plus2_o      = m_q.pc_plus2;
    assign wb_alu_result_o    = m_q.alu_result;
    assign wb_mem_read_o      = m_q.mem_read ? dmem.rdata : 16'h0000;

endmodule
